// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU controller: LSB-first ripple through one full-adder slice per cycle.
// Optional overflow flag output is compiled in when SERIAL_ALU_OVF_EN is defined.
module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             M,
  input  logic             S1,
  input  logic             S0,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             busy,
  output logic             done,
`ifdef SERIAL_ALU_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             m_r;
  logic [1:0]       s_r;
  logic [CW-1:0]    cnt;
  logic             c;
`ifdef SERIAL_ALU_OVF_EN
  logic             c_msb;
`endif

  logic x, y, cin, sum, c_nxt;

  assign dbg_state = state;

  // One slice: logic ops pass x straight through with y and carry held at 0.
  always_comb begin
    x   = 1'b0;
    y   = 1'b0;
    cin = c;
    if (!m_r) begin
      cin = 1'b0;
      case (s_r)
        2'b00:   x = a_r[0] & b_r[0];
        2'b01:   x = a_r[0] | b_r[0];
        2'b10:   x = a_r[0] ^ b_r[0];
        default: x = ~a_r[0];
      endcase
    end else begin
      x = a_r[0];
      case (s_r)
        2'b00:   y = b_r[0];
        2'b01:   y = ~b_r[0];
        2'b10:   y = 1'b0;
        default: y = 1'b1;
      endcase
    end
    sum   = x ^ y ^ cin;
    c_nxt = (x & y) | (x & cin) | (y & cin);
  end

  // Handshake: start is taken only in IDLE and not while done is still high;
  // done pulses for one cycle after DONE, and busy is high exactly during SHIFT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      m_r    <= 1'b0;
      s_r    <= 2'b00;
      cnt    <= '0;
      c      <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
      c_msb  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !done) begin
            a_r   <= a;
            b_r   <= b;
            m_r   <= M;
            s_r   <= {S1, S0};
            cnt   <= '0;
            c     <= M & (S1 ^ S0);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          result <= {sum, result[WIDTH-1:1]};
          a_r    <= a_r >> 1;
          b_r    <= b_r >> 1;
          c      <= c_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            busy  <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
            c_msb <= cin;
`endif
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          cout  <= c;
          zero  <= (result == '0);
`ifdef SERIAL_ALU_OVF_EN
          ovf   <= m_r & (c_msb ^ c);
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Scoreboard bench for serial_alu_ctrl: WIDTH=8 directed vectors plus a WIDTH=4 exhaustive sweep.
module tb_serial_alu_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       m8 = 1'b0, s18 = 1'b0, s08 = 1'b0;
  logic [7:0] result8;
  logic       cout8, zero8, busy8, done8, ovf8;
  logic [1:0] st8;

  // WIDTH=4 instance
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       m4 = 1'b0, s14 = 1'b0, s04 = 1'b0;
  logic [3:0] result4;
  logic       cout4, zero4, busy4, done4, ovf4;
  logic [1:0] st4;

`ifndef SERIAL_ALU_OVF_EN
  assign ovf8 = 1'b0;
  assign ovf4 = 1'b0;
`endif

  serial_alu_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .M(m8), .S1(s18), .S0(s08),
    .result(result8), .cout(cout8), .zero(zero8), .busy(busy8), .done(done8),
`ifdef SERIAL_ALU_OVF_EN
    .ovf(ovf8),
`endif
    .dbg_state(st8)
  );

  serial_alu_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .M(m4), .S1(s14), .S0(s04),
    .result(result4), .cout(cout4), .zero(zero4), .busy(busy4), .done(done4),
`ifdef SERIAL_ALU_OVF_EN
    .ovf(ovf4),
`endif
    .dbg_state(st4)
  );

  // {ovf, zero, cout, result zero-extended to 32 bits}
  typedef logic [34:0] exp_t;
  exp_t exp8_q[$];
  exp_t exp4_q[$];

  typedef struct {
    logic [7:0] a, b;
    logic       m;
    logic [1:0] s;
    logic [7:0] r;
    logic       co, z, ov;
  } vec_t;
  vec_t tv [12];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t vec_exp(input vec_t v);
    logic ov;
    ov = 1'b0;
`ifdef SERIAL_ALU_OVF_EN
    ov = v.ov;
`endif
    return {ov, v.z, v.co, 24'b0, v.r};
  endfunction

  // Word-level reference model for any width 2..32.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic m, input logic [1:0] s);
    logic [32:0] mask, full, lower, y, av;
    logic [31:0] res;
    logic        co, ov;
    int          cin;
    mask = (33'd1 << w) - 33'd1;
    av   = {1'b0, a} & mask;
    co   = 1'b0;
    ov   = 1'b0;
    y    = '0;
    cin  = 0;
    if (!m) begin
      case (s)
        2'd0:    full = av & {1'b0, b};
        2'd1:    full = av | {1'b0, b};
        2'd2:    full = av ^ {1'b0, b};
        default: full = ~av;
      endcase
      full = full & mask;
    end else begin
      case (s)
        2'd0:    begin y = {1'b0, b} & mask;  cin = 0; end
        2'd1:    begin y = ~{1'b0, b} & mask; cin = 1; end
        2'd2:    begin y = '0;                cin = 1; end
        default: begin y = mask;              cin = 0; end
      endcase
      full  = av + y + 33'(cin);
      co    = full[w];
      lower = (av & (mask >> 1)) + (y & (mask >> 1)) + 33'(cin);
      ov    = lower[w-1] ^ co;
    end
    res = full[31:0] & mask[31:0];
`ifndef SERIAL_ALU_OVF_EN
    ov = 1'b0;
`endif
    return {ov, (res == 32'd0), co, res};
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      check("busy8_with_done", {63'b0, busy8}, 64'd0);
      if (exp8_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_done8: got done=1 expected no done (t=%0t)", $time);
      end else begin
        e = exp8_q.pop_front();
        check("op8", {29'b0, ovf8, zero8, cout8, 24'b0, result8}, {29'b0, e});
      end
    end
    if (done4) begin
      check("busy4_with_done", {63'b0, busy4}, 64'd0);
      if (exp4_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_done4: got done=1 expected no done (t=%0t)", $time);
      end else begin
        e = exp4_q.pop_front();
        check("op4", {29'b0, ovf4, zero4, cout4, 28'b0, result4}, {29'b0, e});
      end
    end
  end

  task automatic op8(input vec_t v, input bit push);
    @(negedge clk);
    a8 = v.a; b8 = v.b; m8 = v.m; {s18, s08} = v.s; start8 = 1'b1;
    if (push) exp8_q.push_back(vec_exp(v));
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
    m8 = 1'($urandom_range(0, 1));   {s18, s08} = 2'($urandom_range(0, 3));
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic m, input logic [1:0] s);
    @(negedge clk);
    a4 = a; b4 = b; m4 = m; {s14, s04} = s; start4 = 1'b1;
    exp4_q.push_back(model(4, {28'b0, a}, {28'b0, b}, m, s));
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15));
    m4 = 1'($urandom_range(0, 1));  {s14, s04} = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done8(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done8) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
    end
  endtask

  task automatic wait_done4();
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (done4) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL op4_timeout: got no done expected done within 20 cycles");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t hv;
    int   k;
    bit   prev_busy;

    tv[0]  = '{8'h3C, 8'h0F, 1'b0, 2'd0, 8'h0C, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{8'hFF, 8'h01, 1'b1, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0};
    tv[2]  = '{8'h7F, 8'h00, 1'b1, 2'd2, 8'h80, 1'b0, 1'b0, 1'b1};
    tv[3]  = '{8'h05, 8'h07, 1'b1, 2'd1, 8'hFE, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{8'h3C, 8'h0F, 1'b0, 2'd1, 8'h3F, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{8'h3C, 8'h0F, 1'b0, 2'd2, 8'h33, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{8'h3C, 8'h55, 1'b0, 2'd3, 8'hC3, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{8'h00, 8'hA5, 1'b1, 2'd3, 8'hFF, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{8'h80, 8'h00, 1'b1, 2'd3, 8'h7F, 1'b1, 1'b0, 1'b1};
    tv[9]  = '{8'h0F, 8'h0F, 1'b0, 2'd2, 8'h00, 1'b0, 1'b1, 1'b0};
    tv[10] = '{8'h10, 8'h10, 1'b1, 2'd1, 8'h00, 1'b1, 1'b1, 1'b0};
    tv[11] = '{8'hC8, 8'h64, 1'b1, 2'd0, 8'h2C, 1'b1, 1'b0, 1'b0};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset8", {54'b0, result8, cout8, zero8, busy8, done8, ovf8}, 64'd0);
    check("reset4", {58'b0, result4, cout4, zero4, busy4, done4, ovf4}, 64'd0);
    rst_n = 1'b1;

    // Directed vectors, with a stray start pulse mid-SHIFT that must be ignored
    for (int i = 0; i < 12; i++) begin
      op8(tv[i], 1'b1);
      @(negedge clk);
      start8 = 1'b1; a8 = 8'($urandom_range(0, 255)); m8 = ~m8;
      @(negedge clk);
      start8 = 1'b0;
      wait_done8("directed");
    end

    // start held during the done cycle is not accepted
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("start_in_done_ignored", {63'b0, busy8}, 64'd0);
    repeat (12) @(negedge clk);

    // start held high for 30 cycles: back-to-back ops, inputs scrambled while busy
    k = 0;
    prev_busy = 1'b0;
    @(negedge clk);
    hv = tv[0];
    a8 = hv.a; b8 = hv.b; m8 = hv.m; {s18, s08} = hv.s; start8 = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (busy8 && !prev_busy) begin
        if (k < 3) exp8_q.push_back(vec_exp(tv[k]));
        k++;
      end
      prev_busy = busy8;
      if (busy8 || k >= 3) begin
        a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
        m8 = 1'($urandom_range(0, 1));   {s18, s08} = 2'($urandom_range(0, 3));
      end else begin
        hv = tv[k];
        a8 = hv.a; b8 = hv.b; m8 = hv.m; {s18, s08} = hv.s;
      end
    end
    start8 = 1'b0;
    check("held_start_ops", 64'(k), 64'd3);
    for (int w = 0; w < 40 && exp8_q.size() != 0; w++) @(negedge clk);
    check("held_start_drained", 64'(exp8_q.size()), 64'd0);
    @(negedge clk);

    // Reset in SHIFT cycle 4 aborts the op with no done pulse
    op8(tv[11], 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_mid_shift", {54'b0, result8, cout8, zero8, busy8, done8, ovf8}, 64'd0);
    repeat (12) @(negedge clk);
    op8('{8'h00, 8'h3C, 1'b1, 2'd3, 8'hFF, 1'b0, 1'b0, 1'b0}, 1'b1);
    wait_done8("after_reset");

    // Exhaustive WIDTH=4 sweep
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int im = 0; im < 2; im++)
          for (int is = 0; is < 4; is++) begin
            op4(4'(ia), 4'(ib), 1'(im), 2'(is));
            wait_done4();
          end

    repeat (5) @(negedge clk);
    check("queue8_empty", 64'(exp8_q.size()), 64'd0);
    check("queue4_empty", 64'(exp4_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
